// File: rtl/sdram_arbit.sv
// sdram_arbit: SDRAM command-bus arbiter (init, refresh, write, read).
// Ports: sysclk_100M/rst_n; init/ref/wr/rd engine buses; acks; init_done,
// grant_err; registered SDRAM pins sdram_cke/cmd/addr/ba.
module sdram_arbit #(
   parameter int unsigned TIMEOUT = 1023,
   parameter logic [3:0]  NOP_CMD = 4'b0111
) (
   input  logic        sysclk_100M,
   input  logic        rst_n,
   input  logic [3:0]  init_cmd,
   input  logic [12:0] init_addr,
   input  logic        init_end,
   input  logic        ref_req,
   output logic        ref_ack,
   input  logic [3:0]  ref_cmd,
   input  logic [12:0] ref_addr,
   input  logic        ref_end,
   input  logic        wr_req,
   output logic        wr_ack,
   input  logic [3:0]  wr_cmd,
   input  logic [12:0] wr_addr,
   input  logic [1:0]  wr_bank,
   input  logic        wr_end,
   input  logic        rd_req,
   output logic        rd_ack,
   input  logic [3:0]  rd_cmd,
   input  logic [12:0] rd_addr,
   input  logic [1:0]  rd_bank,
   input  logic        rd_end,
   output logic        init_done,
   output logic        grant_err,
   output logic        sdram_cke,
   output logic [3:0]  sdram_cmd,
   output logic [12:0] sdram_addr,
   output logic [1:0]  sdram_ba
);

   typedef enum logic [4:0] {
      S_INIT  = 5'b00001,
      S_ARBIT = 5'b00010,
      S_REF   = 5'b00100,
      S_WR    = 5'b01000,
      S_RD    = 5'b10000
   } state_t;

   localparam logic [9:0] TMO    = 10'(TIMEOUT);
   localparam logic [9:0] TMO_M1 = 10'(TIMEOUT - 1);

   state_t      r_state, w_next;
   logic        r_last_wr;
   logic [9:0]  r_wdog;
   logic        r_ref_ack, r_wr_ack, r_rd_ack;
   logic        r_init_done, r_grant_err;
   logic [3:0]  r_cmd, w_cmd;
   logic [12:0] r_addr, w_addr;
   logic [1:0]  r_ba, w_ba;
   logic        w_svc, w_end, w_tmo;
   logic        w_pick_wr, w_pick_rd;

   // Both requesting: the one not granted last time wins.
   assign w_pick_wr = wr_req && (!rd_req || !r_last_wr);
   assign w_pick_rd = rd_req && (!wr_req ||  r_last_wr);

   always_comb begin
      w_svc = (r_state == S_REF) || (r_state == S_WR) ||
              (r_state == S_RD);
      w_end = ((r_state == S_REF) && ref_end) ||
              ((r_state == S_WR)  && wr_end)  ||
              ((r_state == S_RD)  && rd_end);
      // r_wdog holds the count of earlier service cycles,
      // so this fires on the TIMEOUT-th cycle; an end wins.
      w_tmo = w_svc && !w_end && (r_wdog >= TMO_M1);
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_INIT:  if (init_end) w_next = S_ARBIT;
         S_ARBIT: begin
            unique case (1'b1)
               ref_req:               w_next = S_REF;
               !ref_req && w_pick_wr: w_next = S_WR;
               !ref_req && w_pick_rd: w_next = S_RD;
               default:               w_next = S_ARBIT;
            endcase
         end
         S_REF, S_WR, S_RD: begin
            if (w_end || w_tmo) w_next = S_ARBIT;
         end
         default: w_next = S_INIT;
      endcase
   end

   always_comb begin
      w_cmd  = NOP_CMD;
      w_addr = '0;
      w_ba   = '0;
      unique case (r_state)
         S_INIT: begin
            w_cmd  = init_cmd;
            w_addr = init_addr;
         end
         S_REF: begin
            w_cmd  = ref_cmd;
            w_addr = ref_addr;
         end
         S_WR: begin
            w_cmd  = wr_cmd;
            w_addr = wr_addr;
            w_ba   = wr_bank;
         end
         S_RD: begin
            w_cmd  = rd_cmd;
            w_addr = rd_addr;
            w_ba   = rd_bank;
         end
         default: ;
      endcase
   end

   always_ff @(posedge sysclk_100M or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_INIT;
         r_last_wr   <= 1'b0;
         r_wdog      <= '0;
         r_ref_ack   <= 1'b0;
         r_wr_ack    <= 1'b0;
         r_rd_ack    <= 1'b0;
         r_init_done <= 1'b0;
         r_grant_err <= 1'b0;
         r_cmd       <= NOP_CMD;
         r_addr      <= '0;
         r_ba        <= '0;
      end else begin
         r_state     <= w_next;
         r_ref_ack   <= (r_state == S_ARBIT) && (w_next == S_REF);
         r_wr_ack    <= (r_state == S_ARBIT) && (w_next == S_WR);
         r_rd_ack    <= (r_state == S_ARBIT) && (w_next == S_RD);
         r_grant_err <= w_tmo;
         r_cmd       <= w_cmd;
         r_addr      <= w_addr;
         r_ba        <= w_ba;
         if ((r_state == S_INIT) && init_end)
            r_init_done <= 1'b1;
         if ((r_state == S_ARBIT) && (w_next == S_WR))
            r_last_wr <= 1'b1;
         else if ((r_state == S_ARBIT) && (w_next == S_RD))
            r_last_wr <= 1'b0;
         if (!w_svc)
            r_wdog <= '0;
         else if (r_wdog < TMO)
            r_wdog <= r_wdog + 10'd1;
      end
   end

   assign ref_ack    = r_ref_ack;
   assign wr_ack     = r_wr_ack;
   assign rd_ack     = r_rd_ack;
   assign init_done  = r_init_done;
   assign grant_err  = r_grant_err;
   assign sdram_cke  = 1'b1;
   assign sdram_cmd  = r_cmd;
   assign sdram_addr = r_addr;
   assign sdram_ba   = r_ba;

endmodule

// File: tb/tb_sdram_arbit.sv
// tb_sdram_arbit: scoreboard bench for sdram_arbit.
// Expected ack/grant_err pulses are queued with their cycle.
module tb_sdram_arbit;

   localparam logic [3:0] NOP = 4'b0111;
   localparam int K_REF = 0, K_WR = 1, K_RD = 2, K_ERR = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  init_cmd;
   logic [12:0] init_addr;
   logic        init_end;
   logic        ref_req, ref_end;
   logic [3:0]  ref_cmd;
   logic [12:0] ref_addr;
   logic        wr_req, wr_end;
   logic [3:0]  wr_cmd;
   logic [12:0] wr_addr;
   logic [1:0]  wr_bank;
   logic        rd_req, rd_end;
   logic [3:0]  rd_cmd;
   logic [12:0] rd_addr;
   logic [1:0]  rd_bank;
   logic        ref_ack, wr_ack, rd_ack;
   logic        init_done, grant_err, sdram_cke;
   logic [3:0]  sdram_cmd;
   logic [12:0] sdram_addr;
   logic [1:0]  sdram_ba;

   sdram_arbit #(.TIMEOUT(15), .NOP_CMD(NOP)) dut (
      .sysclk_100M(clk), .rst_n(rst_n),
      .init_cmd(init_cmd), .init_addr(init_addr),
      .init_end(init_end),
      .ref_req(ref_req), .ref_ack(ref_ack),
      .ref_cmd(ref_cmd), .ref_addr(ref_addr), .ref_end(ref_end),
      .wr_req(wr_req), .wr_ack(wr_ack), .wr_cmd(wr_cmd),
      .wr_addr(wr_addr), .wr_bank(wr_bank), .wr_end(wr_end),
      .rd_req(rd_req), .rd_ack(rd_ack), .rd_cmd(rd_cmd),
      .rd_addr(rd_addr), .rd_bank(rd_bank), .rd_end(rd_end),
      .init_done(init_done), .grant_err(grant_err),
      .sdram_cke(sdram_cke), .sdram_cmd(sdram_cmd),
      .sdram_addr(sdram_addr), .sdram_ba(sdram_ba)
   );

   always #5 clk = ~clk;

   typedef struct {
      int kind;
      int cyc;
   } ev_t;

   ev_t   q[$];
   int    cyc = 0;
   int    n_cmp = 0;
   int    n_err = 0;
   string kname[4] = '{"ref_ack", "wr_ack", "rd_ack", "grant_err"};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int k, input int c);
      ev_t e;
      e.kind = k;
      e.cyc  = c;
      q.push_back(e);
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   // Monitor: every pulse seen must match the head of the queue.
   always @(negedge clk) begin
      logic [3:0] v;
      ev_t e;
      v = {grant_err, rd_ack, wr_ack, ref_ack};
      if (rst_n === 1'b1) begin
         for (int k = 0; k < 4; k++) begin
            if (v[k]) begin
               n_cmp++;
               if (q.size() == 0) begin
                  n_err++;
                  $display("FAIL unexpected %s at cycle %0d",
                           kname[k], cyc);
               end else begin
                  e = q.pop_front();
                  if (e.kind != k || e.cyc != cyc) begin
                     n_err++;
                     $display("FAIL %s: got %s@%0d, expected %s@%0d",
                              "pulse", kname[k], cyc,
                              kname[e.kind], e.cyc);
                  end
               end
            end
         end
      end
   end

   task automatic set_req(input int k, input logic v);
      case (k)
         K_REF:   ref_req = v;
         K_WR:    wr_req  = v;
         default: rd_req  = v;
      endcase
   endtask

   task automatic set_end(input int k, input logic v);
      case (k)
         K_REF:   ref_end = v;
         K_WR:    wr_end  = v;
         default: rd_end  = v;
      endcase
   endtask

   // Called in an S_ARBIT cycle where kind k will win. Holds the
   // grant for len service cycles and returns in the next S_ARBIT.
   task automatic serve(input int k, input int len, input bit drop);
      push(k, cyc + 1);
      tick();
      if (drop) set_req(k, 1'b0);
      repeat (len - 1) tick();
      set_end(k, 1'b1);
      tick();
      set_end(k, 1'b0);
   endtask

   initial begin
      int a;
      rst_n = 1'b0;
      init_cmd = 4'b0001; init_addr = 13'h400; init_end = 1'b0;
      ref_req = 0; ref_end = 0; ref_cmd = 4'b0001; ref_addr = 13'h0;
      wr_req = 0; wr_end = 0; wr_cmd = 4'b0100;
      wr_addr = 13'h0A5; wr_bank = 2'd2;
      rd_req = 0; rd_end = 0; rd_cmd = 4'b0101;
      rd_addr = 13'h1C3; rd_bank = 2'd1;
      tick(); tick();
      chk("rst_cmd", 32'(sdram_cmd), 32'(NOP));
      chk("rst_addr", 32'(sdram_addr), 0);
      chk("rst_ba", 32'(sdram_ba), 0);
      chk("rst_cke", 32'(sdram_cke), 1);
      chk("rst_acks", 32'({ref_ack, wr_ack, rd_ack, grant_err}), 0);
      chk("rst_init_done", 32'(init_done), 0);

      rst_n = 1'b1;
      wr_req = 1'b1;
      repeat (20) tick();
      chk("init_pin_cmd", 32'(sdram_cmd), 32'h1);
      chk("init_pin_addr", 32'(sdram_addr), 32'h400);
      chk("init_done_lo", 32'(init_done), 0);
      init_end = 1'b1;
      push(K_WR, cyc + 2);
      tick();
      init_end = 1'b0;
      chk("init_done_hi", 32'(init_done), 1);
      tick();
      wr_req = 1'b0;
      tick();
      chk("wr_pin_cmd", 32'(sdram_cmd), 32'h4);
      chk("wr_pin_addr", 32'(sdram_addr), 32'h0A5);
      chk("wr_pin_ba", 32'(sdram_ba), 2);
      wr_end = 1'b1;
      tick();
      wr_end = 1'b0;
      tick();
      chk("release_cmd", 32'(sdram_cmd), 32'(NOP));
      chk("release_ba", 32'(sdram_ba), 0);

      rd_req = 1'b1;
      serve(K_RD, 2, 1'b1);

      ref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
      serve(K_REF, 3, 1'b1);
      serve(K_WR, 3, 1'b1);
      serve(K_RD, 3, 1'b1);

      wr_req = 1'b1; rd_req = 1'b1;
      serve(K_WR, 10, 1'b0);
      serve(K_RD, 10, 1'b0);
      serve(K_WR, 10, 1'b0);
      serve(K_RD, 10, 1'b0);
      wr_req = 1'b0; rd_req = 1'b0;
      tick();

      rd_req = 1'b1;
      push(K_RD, cyc + 1);
      tick();
      rd_req = 1'b0;
      a = cyc;
      push(K_ERR, a + 15);
      repeat (14) tick();
      chk("tmo_held_cmd", 32'(sdram_cmd), 32'h5);
      tick();
      tick();
      chk("tmo_nop_cmd", 32'(sdram_cmd), 32'(NOP));
      chk("tmo_nop_addr", 32'(sdram_addr), 0);

      rd_req = 1'b1;
      serve(K_RD, 15, 1'b1);
      tick();

      rd_req = 1'b1;
      push(K_RD, cyc + 1);
      tick();
      rd_req = 1'b0;
      tick();
      wr_end = 1'b1; ref_end = 1'b1;
      tick();
      wr_end = 1'b0; ref_end = 1'b0;
      tick();
      chk("foreign_end_ign", 32'(sdram_cmd), 32'h5);
      chk("foreign_end_ba", 32'(sdram_ba), 1);
      rd_end = 1'b1; ref_req = 1'b1;
      push(K_REF, cyc + 2);
      tick();
      rd_end = 1'b0;
      tick();
      ref_req = 1'b0;
      tick();
      ref_end = 1'b1;
      tick();
      ref_end = 1'b0;

      wr_req = 1'b1;
      push(K_WR, cyc + 1);
      tick();
      wr_req = 1'b0;
      tick();
      chk("pre_rst_cmd", 32'(sdram_cmd), 32'h4);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_cmd", 32'(sdram_cmd), 32'(NOP));
      chk("async_rst_addr", 32'(sdram_addr), 0);
      chk("async_rst_ba", 32'(sdram_ba), 0);
      chk("async_rst_done", 32'(init_done), 0);
      tick();
      rst_n = 1'b1;
      init_cmd = 4'b0010;
      wr_req = 1'b1;
      tick();
      tick();
      chk("reinit_pin_cmd", 32'(sdram_cmd), 32'h2);
      chk("reinit_done", 32'(init_done), 0);
      wr_req = 1'b0;
      repeat (3) tick();
      chk("queue_empty", 32'(q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
